// File: rtl/mandala_pkg.sv
// Shared types and constants for the mandala frame controller slice.
package mandala_pkg;

    // Controller modes: free-running, frozen, frozen with one frame step armed
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PAUSE     = 2'd1,
        STEP_PEND = 2'd2
    } mandala_state_t;

    localparam logic [7:0] LFSR_RESET         = 8'hA5;
    localparam int         LFSR_TAP_A         = 7;
    localparam int         LFSR_TAP_B         = 5;
    localparam int         DEBOUNCE_W_DEFAULT = 16;

    // One shift of the sparkle LFSR: shift left, feedback into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

    // An all-zero seed would lock the LFSR, so substitute the reset pattern
    function automatic logic [7:0] seed_sanitize(input logic [7:0] s);
        return (s == 8'd0) ? LFSR_RESET : s;
    endfunction

endpackage

// File: rtl/mandala_frame_ctrl_btn_debounce.sv
// Button conditioner: synchronizer chain, persistence debouncer and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce
    import mandala_pkg::*;
#(
    parameter int DEBOUNCE_W  = DEBOUNCE_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_sr;
    logic                   sync_lvl;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   stable;
    logic                   stable_d;

    assign sync_lvl = sync_sr[SYNC_STAGES-1];

    // Metastability chain bringing the raw button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr <= '0;
        end else begin
            sync_sr[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_sr[i] <= sync_sr[i-1];
            end
        end
    end

    // Accept a new level only after it has persisted for 2^DEBOUNCE_W cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
            if (sync_lvl == stable) begin
                cnt <= '0;
            end else if (&cnt) begin
                stable <= sync_lvl;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Releases are deliberately silent; only the rising edge is a press
    assign press = stable & ~stable_d;

endmodule

// File: rtl/mandala_frame_ctrl.sv
// Frame-synchronous parameter controller: debounced buttons, frame tick,
// speed prescaler, run/pause/step FSM, pattern counter and sparkle LFSR.
module mandala_frame_ctrl
    import mandala_pkg::*;
#(
    parameter int DEBOUNCE_W  = DEBOUNCE_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       btn_pause,
    input  logic       btn_step,
    input  logic       btn_reseed,
    input  logic [1:0] speed,
    input  logic [7:0] seed_in,
    output logic [7:0] pattern_counter,
    output logic [7:0] lfsr,
    output logic       frame_tick,
    output logic       paused
);

    logic           pause_press;
    logic           step_press;
    logic           reseed_press;
    logic [1:0]     speed_sr [SYNC_STAGES];
    logic [1:0]     speed_sync;
    logic [1:0]     speed_q;
    logic           vsync_d;
    logic [2:0]     prescaler;
    logic [2:0]     due_mask;
    logic           due;
    logic           enter_run;
    mandala_state_t state;

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W), .SYNC_STAGES(SYNC_STAGES)) u_pause (
        .clk(clk), .rst_n(rst_n), .raw(btn_pause), .press(pause_press)
    );

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W), .SYNC_STAGES(SYNC_STAGES)) u_step (
        .clk(clk), .rst_n(rst_n), .raw(btn_step), .press(step_press)
    );

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W), .SYNC_STAGES(SYNC_STAGES)) u_reseed (
        .clk(clk), .rst_n(rst_n), .raw(btn_reseed), .press(reseed_press)
    );

    assign speed_sync = speed_sr[SYNC_STAGES-1];

    // Speed select is a slow switch, so it is synchronized but not debounced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                speed_sr[i] <= 2'd0;
            end
        end else begin
            speed_sr[0] <= speed;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                speed_sr[i] <= speed_sr[i-1];
            end
        end
    end

    // Frame tick on vsync rise; speed only changes at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            frame_tick <= 1'b0;
            speed_q    <= 2'd0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= vsync & ~vsync_d;
            if (frame_tick) begin
                speed_q <= speed_sync;
            end
        end
    end

    // Low speed_q bits of the prescaler must all be set for a due frame
    always_comb begin
        due_mask = 3'b000;
        case (speed_q)
            2'd0:    due_mask = 3'b000;
            2'd1:    due_mask = 3'b001;
            2'd2:    due_mask = 3'b011;
            default: due_mask = 3'b111;
        endcase
    end

    assign due       = ((prescaler & due_mask) == due_mask);
    assign enter_run = (state != RUN) && pause_press;

    // Mode FSM with the frame counter and prescaler it governs; a pause
    // press always has priority over a pending step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            paused          <= 1'b0;
            pattern_counter <= 8'd0;
            prescaler       <= 3'd0;
        end else begin
            if (enter_run) begin
                prescaler <= 3'd0;
            end else if (frame_tick) begin
                prescaler <= due ? 3'd0 : prescaler + 3'd1;
            end

            case (state)
                RUN: begin
                    if (frame_tick && due) begin
                        pattern_counter <= pattern_counter + 8'd1;
                    end
                    if (pause_press) begin
                        state  <= PAUSE;
                        paused <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_press) begin
                        state  <= RUN;
                        paused <= 1'b0;
                    end else if (step_press) begin
                        state  <= STEP_PEND;
                        paused <= 1'b1;
                    end
                end
                STEP_PEND: begin
                    if (pause_press) begin
                        state  <= RUN;
                        paused <= 1'b0;
                    end else if (frame_tick) begin
                        pattern_counter <= pattern_counter + 8'd1;
                        state           <= PAUSE;
                        paused          <= 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    paused <= 1'b0;
                end
            endcase
        end
    end

    // Sparkle LFSR free-runs only in RUN; a reseed wins in every mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_RESET;
        end else if (reseed_press) begin
            lfsr <= seed_sanitize(seed_in);
        end else if (state == RUN) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: tb/tb_mandala_frame_ctrl.sv
// Directed bench for mandala_frame_ctrl with a cycle-level reference model.
module tb_mandala_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_reseed = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [7:0] seed_in = 8'd0;
    logic [7:0] pattern_counter;
    logic [7:0] lfsr;
    logic       frame_tick;
    logic       paused;

    int checks = 0;
    int failures = 0;

    mandala_frame_ctrl #(.DEBOUNCE_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync),
        .btn_pause(btn_pause), .btn_step(btn_step), .btn_reseed(btn_reseed),
        .speed(speed), .seed_in(seed_in),
        .pattern_counter(pattern_counter), .lfsr(lfsr),
        .frame_tick(frame_tick), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 running, 1 frozen, 2 frozen with a step armed
    logic [7:0] m_pc, m_lfsr;
    bit         m_ft, m_paused, m_vs_d;
    int         m_mode, m_sq, m_frames;
    logic [1:0] sp0, sp1;
    bit         rh0[3], rh1[3], stab[3], prs[3];
    int         run_len[3];

    task automatic model_reset();
        m_pc = 8'd0; m_lfsr = 8'hA5; m_ft = 0; m_paused = 0; m_vs_d = 0;
        m_mode = 0; m_sq = 0; m_frames = 0; sp0 = 2'd0; sp1 = 2'd0;
        for (int b = 0; b < 3; b++) begin
            rh0[b] = 0; rh1[b] = 0; stab[b] = 0; prs[b] = 0; run_len[b] = 0;
        end
    endtask

    task automatic model_step();
        bit   raw[3];
        int   period, nmode;
        bit   due, sv, was;
        raw[0] = btn_pause; raw[1] = btn_step; raw[2] = btn_reseed;
        period = 1 << m_sq;
        due = ((m_frames % period) == period - 1);
        nmode = m_mode;
        if (prs[2]) m_lfsr = (seed_in == 8'd0) ? 8'hA5 : seed_in;
        else if (m_mode == 0) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5]};
        case (m_mode)
            0: begin
                if (m_ft && due) m_pc = m_pc + 8'd1;
                if (prs[0]) nmode = 1;
            end
            1: begin
                if (prs[0]) nmode = 0;
                else if (prs[1]) nmode = 2;
            end
            default: begin
                if (prs[0]) nmode = 0;
                else if (m_ft) begin
                    m_pc = m_pc + 8'd1;
                    nmode = 1;
                end
            end
        endcase
        if (nmode == 0 && m_mode != 0) m_frames = 0;
        else if (m_ft) m_frames = due ? 0 : (m_frames + 1) % 8;
        m_mode = nmode;
        m_paused = (nmode != 0);
        if (m_ft) m_sq = int'(sp1);
        m_ft = vsync && !m_vs_d;
        m_vs_d = vsync;
        sp1 = sp0; sp0 = speed;
        for (int b = 0; b < 3; b++) begin
            sv = rh1[b];
            was = stab[b];
            if (sv != stab[b]) begin
                run_len[b]++;
                if (run_len[b] == 16) begin
                    stab[b] = sv;
                    run_len[b] = 0;
                end
            end else begin
                run_len[b] = 0;
            end
            prs[b] = stab[b] && !was;
            rh1[b] = rh0[b];
            rh0[b] = raw[b];
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        check8("cyc_pattern_counter", pattern_counter, m_pc);
        check8("cyc_lfsr", lfsr, m_lfsr);
        check8("cyc_frame_tick", 8'(frame_tick), 8'(m_ft));
        check8("cyc_paused", 8'(paused), 8'(m_paused));
    end

    // ---------------- stimulus ----------------
    task automatic step_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic frame(input int hi, input int lo);
        vsync = 1'b1;
        step_edges(hi);
        vsync = 1'b0;
        step_edges(lo);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_pause = v;
            1: btn_step = v;
            default: btn_reseed = v;
        endcase
    endtask

    task automatic press_btn(input int b, input int hold);
        set_btn(b, 1'b1);
        step_edges(hold);
        set_btn(b, 1'b0);
        step_edges(22);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pc_hold, lfsr_hold, pc_exp;
        int bounce[8];
        bounce = '{1, 1, 1, 0, 0, 1, 1, 0};

        // Reset state
        step_edges(3);
        check8("rst_pattern_counter", pattern_counter, 8'd0);
        check8("rst_lfsr", lfsr, 8'hA5);
        check8("rst_frame_tick", 8'(frame_tick), 8'd0);
        check8("rst_paused", 8'(paused), 8'd0);
        rst_n = 1'b1;
        check8("lfsr_after_release", lfsr, 8'hA5);
        step_edges(1);
        check8("lfsr_first_shift", lfsr, 8'h4A);

        // Speed 0: one increment per frame
        for (int i = 1; i <= 3; i++) begin
            frame(2, 6);
            check8("run_count", pattern_counter, 8'(i));
        end

        // Speed 2: once per four frames after the latching frame
        speed = 2'd2;
        step_edges(4);
        frame(2, 6);
        check8("speed2_latch_frame", pattern_counter, 8'd4);
        for (int i = 0; i < 3; i++) frame(2, 6);
        check8("speed2_hold3", pattern_counter, 8'd4);
        frame(2, 6);
        check8("speed2_fourth", pattern_counter, 8'd5);
        speed = 2'd0;
        step_edges(3);
        frame(2, 6);
        check8("speed0_not_yet", pattern_counter, 8'd5);
        frame(2, 6);
        check8("speed0_active", pattern_counter, 8'd6);

        // Glitch rejection
        btn_pause = 1'b1;
        step_edges(10);
        btn_pause = 1'b0;
        step_edges(30);
        check8("glitch_no_pause", 8'(paused), 8'd0);

        // Held press: accepted 18 edges after the rise, seen on edge 19
        btn_pause = 1'b1;
        step_edges(18);
        check8("press_edge18", 8'(paused), 8'd0);
        step_edges(1);
        check8("press_edge19", 8'(paused), 8'd1);
        btn_pause = 1'b0;
        step_edges(22);

        // Bouncing press yields a single toggle back to RUN
        for (int i = 0; i < 8; i++) begin
            btn_pause = bounce[i][0];
            step_edges(1);
        end
        btn_pause = 1'b1;
        step_edges(25);
        btn_pause = 1'b0;
        step_edges(22);
        check8("bounce_single_press", 8'(paused), 8'd0);

        // Pause and hold across frames
        press_btn(0, 25);
        check8("paused_again", 8'(paused), 8'd1);
        pc_hold = m_pc;
        lfsr_hold = m_lfsr;
        for (int i = 0; i < 3; i++) frame(2, 6);
        check8("pause_pc_hold", pattern_counter, pc_hold);
        check8("pause_lfsr_hold", lfsr, lfsr_hold);

        // Single step
        press_btn(1, 25);
        check8("step_pending_paused", 8'(paused), 8'd1);
        check8("step_pending_pc", pattern_counter, pc_hold);
        frame(2, 6);
        pc_exp = pc_hold + 8'd1;
        check8("step_pc", pattern_counter, pc_exp);
        check8("step_back_paused", 8'(paused), 8'd1);
        frame(2, 6);
        check8("step_only_once", pattern_counter, pc_exp);

        // Step then pause: pending step dropped
        press_btn(1, 25);
        press_btn(0, 25);
        check8("step_cancel_run", 8'(paused), 8'd0);
        check8("step_cancel_pc", pattern_counter, pc_exp);

        // Wrap with coincident pause press
        for (int i = 0; i < 300 && m_pc != 8'd255; i++) frame(1, 3);
        check8("pre_wrap_pc", pattern_counter, 8'd255);
        btn_pause = 1'b1;
        step_edges(17);
        vsync = 1'b1;
        step_edges(1);
        vsync = 1'b0;
        step_edges(1);
        check8("wrap_pc", pattern_counter, 8'd0);
        check8("wrap_paused", 8'(paused), 8'd1);
        btn_pause = 1'b0;
        step_edges(22);

        // Reseed in RUN
        press_btn(0, 25);
        check8("reseed_run", 8'(paused), 8'd0);
        seed_in = 8'h3C;
        btn_reseed = 1'b1;
        step_edges(19);
        check8("reseed_load", lfsr, 8'h3C);
        step_edges(1);
        check8("reseed_shift", lfsr, 8'h79);
        btn_reseed = 1'b0;
        step_edges(22);
        seed_in = 8'h00;
        btn_reseed = 1'b1;
        step_edges(19);
        check8("reseed_zero", lfsr, 8'hA5);
        step_edges(1);
        check8("reseed_zero_shift", lfsr, 8'h4A);
        btn_reseed = 1'b0;
        step_edges(22);

        // Reset while a step is pending
        press_btn(0, 25);
        press_btn(1, 25);
        check8("stepfin_paused", 8'(paused), 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check8("midrst_pattern_counter", pattern_counter, 8'd0);
        check8("midrst_lfsr", lfsr, 8'hA5);
        check8("midrst_frame_tick", 8'(frame_tick), 8'd0);
        check8("midrst_paused", 8'(paused), 8'd0);
        step_edges(3);
        rst_n = 1'b1;
        frame(2, 6);
        check8("post_reset_run", pattern_counter, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
